// File: rtl/dt_conv_pkg.sv
// Shared types and defaults for the DT<->STM converter.
// Frame width default and receive frame-state encoding.
package dt_conv_pkg;

    localparam int DT_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_COMMIT
    } rx_state_t;

endpackage

// File: rtl/stm_sync_edge.sv
// Synchronises one asynchronous STM input into the c4 domain and flags its edges.
// Latency: level, rise and fall all change together, SYNC_STAGES+1 c4 edges after the input.
module stm_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic c4,
    input  logic reset_in_rg,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;

    always_ff @(posedge c4 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            sync_chain <= {SYNC_STAGES{RST_VAL}};
            level      <= RST_VAL;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
            level      <= sync_chain[SYNC_STAGES-1];
            rise       <= sync_chain[SYNC_STAGES-1] & ~level;
            fall       <= ~sync_chain[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/dt_frame_receiver.sv
// DT receive path: one FRAME_BITS word per f0 frame into a hold register, read MSB-first by the STM.
// cpu_int rises two c4 edges after the last data bit; DT_RX_ERR_CNT_EN adds the err_cnt output.
module dt_frame_receiver
    import dt_conv_pkg::*;
#(
    parameter int FRAME_BITS  = DT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic       c4,
    input  logic       reset_in_rg,
    input  logic       f0,
    input  logic       data_from_dt,
    input  logic       select,
    input  logic       clk_from_stm,
    output logic       data_to_stm,
    output logic       cpu_int,
`ifdef DT_RX_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       overrun
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);

    rx_state_t             state;
    logic                  f0_q;
    logic [CW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] hold_reg;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         clk_cnt;

    logic sel_lvl, sel_rise, sel_fall;
    logic clk_fall, unused_clk_lvl, unused_clk_rise;

    logic f0_fall, reading, consume, commit, ovr_set;

    stm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
        .c4          (c4),
        .reset_in_rg (reset_in_rg),
        .din         (select),
        .level       (sel_lvl),
        .rise        (sel_rise),
        .fall        (sel_fall)
    );

    stm_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
        .c4          (c4),
        .reset_in_rg (reset_in_rg),
        .din         (clk_from_stm),
        .level       (unused_clk_lvl),
        .rise        (unused_clk_rise),
        .fall        (clk_fall)
    );

    assign f0_fall = ~f0 & f0_q;
    assign reading = ~sel_lvl;
    assign consume = sel_rise && (clk_cnt == FULL_CNT);
    assign commit  = (state == RX_COMMIT) && !f0_fall;
    // A consuming deselect in the commit cycle frees the hold register, so no word is lost.
    assign ovr_set = commit && (reading || (cpu_int && !consume));

    always_ff @(posedge c4 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            state     <= RX_IDLE;
            f0_q      <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            cpu_int   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            f0_q    <= f0;
            overrun <= ovr_set;
            if (consume)
                cpu_int <= 1'b0;
            if (f0_fall) begin
                state     <= RX_SHIFT;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else begin
                case (state)
                    RX_IDLE: state <= RX_IDLE;
                    RX_SHIFT: begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], data_from_dt};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state <= RX_COMMIT;
                    end
                    RX_COMMIT: begin
                        state <= RX_IDLE;
                        if (!reading) begin
                            hold_reg <= shift_reg;
                            cpu_int  <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // The pointer parks on the MSB while deselected, so a new read never shows a stale bit.
    always_ff @(posedge c4 or posedge reset_in_rg) begin
        if (reset_in_rg) begin
            rd_ptr      <= LAST_BIT;
            clk_cnt     <= '0;
            data_to_stm <= 1'b0;
        end else begin
            if (sel_lvl)
                rd_ptr <= LAST_BIT;
            else if (clk_fall && rd_ptr != '0)
                rd_ptr <= rd_ptr - 1'b1;

            if (sel_fall)
                clk_cnt <= '0;
            else if (reading && clk_fall && clk_cnt != FULL_CNT)
                clk_cnt <= clk_cnt + 1'b1;

            data_to_stm <= sel_lvl ? 1'b0 : hold_reg[rd_ptr[IW-1:0]];
        end
    end

`ifdef DT_RX_ERR_CNT_EN
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    assign err_inc = {1'b0, (f0_fall && state == RX_SHIFT)} + {1'b0, ovr_set};
    assign err_sum = {1'b0, err_cnt} + {7'd0, err_inc};

    always_ff @(posedge c4 or posedge reset_in_rg) begin
        if (reset_in_rg)
            err_cnt <= 8'd0;
        else
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_dt_frame_receiver.sv
// Directed bench for dt_frame_receiver: frame capture, STM readback, aborts, overruns and reset.
module tb_dt_frame_receiver;

    logic c4 = 1'b0;
    logic reset_in_rg = 1'b1;
    logic f0 = 1'b1;
    logic data_from_dt = 1'b0;
    logic select = 1'b1;
    logic clk_from_stm = 1'b1;
    logic data_to_stm, cpu_int, overrun;
`ifdef DT_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;
    logic [31:0] got;

    always #5 c4 = ~c4;

    dt_frame_receiver dut (
        .c4           (c4),
        .reset_in_rg  (reset_in_rg),
        .f0           (f0),
        .data_from_dt (data_from_dt),
        .select       (select),
        .clk_from_stm (clk_from_stm),
        .data_to_stm  (data_to_stm),
        .cpu_int      (cpu_int),
`ifdef DT_RX_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .overrun      (overrun)
    );

    always @(negedge c4) if (overrun === 1'b1) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // f0 low for exactly one edge (N), then nbits MSB-first ahead of edges N+1..
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit check_early);
        @(negedge c4) f0 = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge c4);
            f0 = 1'b1;
            data_from_dt = word[31-i];
        end
        if (nbits == 32) begin
            @(posedge c4) #1;
            if (check_early) check("cpu_int_before_commit", {31'd0, cpu_int}, 32'd0);
            @(posedge c4);
            @(posedge c4) #1;
            check("cpu_int_after_commit", {31'd0, cpu_int}, 32'd1);
        end
    endtask

    // STM clock at c4/8; each bit is sampled just before the falling edge that advances it.
    task automatic stm_read(input int nclk, output logic [31:0] word);
        word = '0;
        @(negedge c4) select = 1'b0;
        repeat (8) @(negedge c4);
        for (int i = 0; i < nclk; i++) begin
            word = {word[30:0], data_to_stm};
            clk_from_stm = 1'b0;
            repeat (4) @(negedge c4);
            clk_from_stm = 1'b1;
            repeat (4) @(negedge c4);
        end
        select = 1'b1;
        repeat (6) @(negedge c4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge c4);
        check("rst_data_to_stm", {31'd0, data_to_stm}, 32'd0);
        check("rst_cpu_int", {31'd0, cpu_int}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset_in_rg = 1'b0;
        repeat (4) @(negedge c4);

        // Basic frame and full readback
        send_frame(32'hA5C3_0F81, 32, 1'b1);
        check("t1_overrun_none", ovr_cnt, 0);
        stm_read(32, got);
        check("t2_read_word", got, 32'hA5C3_0F81);
        check("t2_cpu_int_consumed", {31'd0, cpu_int}, 32'd0);
        check("t2_data_idle", {31'd0, data_to_stm}, 32'd0);

        // Short frame is dropped, following full frame lands
        send_frame(32'hDEAD_BEEF, 20, 1'b0);
        check("t3_partial_no_int", {31'd0, cpu_int}, 32'd0);
        send_frame(32'h1234_5678, 32, 1'b1);
        check("t3_overrun_none", ovr_cnt, 0);
`ifdef DT_RX_ERR_CNT_EN
        check("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        stm_read(32, got);
        check("t3_read_word", got, 32'h1234_5678);

        // Two unread frames overrun; an aborted read leaves the word pending
        send_frame(32'h1111_2222, 32, 1'b1);
        send_frame(32'h3333_4444, 32, 1'b0);
        check("t4_overrun_count", ovr_cnt, 1);
        stm_read(8, got);
        check("t4_abort_keeps_int", {31'd0, cpu_int}, 32'd1);
        stm_read(32, got);
        check("t4_read_second_word", got, 32'h3333_4444);
        check("t4_cpu_int_consumed", {31'd0, cpu_int}, 32'd0);

        // A commit during an active read is discarded
        send_frame(32'hFFFF_0000, 32, 1'b1);
        fork
            stm_read(32, got);
            begin
                repeat (40) @(negedge c4);
                send_frame(32'h0000_FFFF, 32, 1'b0);
            end
        join
        check("t5_read_word", got, 32'hFFFF_0000);
        check("t5_overrun_count", ovr_cnt, 2);
        check("t5_cpu_int_consumed", {31'd0, cpu_int}, 32'd0);
`ifdef DT_RX_ERR_CNT_EN
        check("t5_err_cnt", {24'd0, err_cnt}, 32'd3);
`endif

        // Reset in the middle of a read and a frame
        send_frame(32'h0F0F_0F0F, 32, 1'b1);
        @(negedge c4) select = 1'b0;
        repeat (8) @(negedge c4);
        for (int i = 0; i < 5; i++) begin
            clk_from_stm = 1'b0;
            repeat (4) @(negedge c4);
            clk_from_stm = 1'b1;
            repeat (4) @(negedge c4);
        end
        check("t6_mid_read_bit26", {31'd0, data_to_stm}, 32'd1);
        send_frame(32'hDEAD_BEEF, 10, 1'b0);
        reset_in_rg = 1'b1;
        select = 1'b1;
        @(posedge c4) #1;
        check("t6_rst_data_to_stm", {31'd0, data_to_stm}, 32'd0);
        check("t6_rst_cpu_int", {31'd0, cpu_int}, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef DT_RX_ERR_CNT_EN
        check("t6_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        repeat (2) @(negedge c4);
        reset_in_rg = 1'b0;
        repeat (4) @(negedge c4);
        send_frame(32'hC0FF_EE11, 32, 1'b1);
        stm_read(32, got);
        check("t6_read_after_reset", got, 32'hC0FF_EE11);
        check("t6_overrun_count", ovr_cnt, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
